// File: rtl/mod_demod_step_gen.sv
// rtl/mod_demod_step_gen.sv - square-wave modulator, synchronous demodulator and error integrator
//
// Purpose: generates a HIGH/LOW modulation square wave, accumulates the
// detector ADC samples of each half (after a settling window), forms the
// demodulated error once per full period and integrates it into a
// saturating step value for a downstream phase ramp.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_adc            signed detector sample, valid every clock
//   i_freq           half-period in clocks (clamped to FREQ_MIN)
//   i_amp_H, i_amp_L modulation high / low levels
//   i_wait_cnt       settling samples skipped at the start of each half
//   i_err_offset     subtracted from the raw error
//   i_polarity       1 inverts the error sign
//   i_gain_sel       integrator right-shift in bits [4:0]
//   i_loop_en        1 enables integration, 0 holds o_step at zero
//   o_mod            registered modulation level
//   o_mod_trig       one-cycle pulse at the start of each full period
//   o_err            demodulated error of the last full period
//   o_step           integrated, saturated step
//   o_step_valid     one-cycle pulse when o_step is updated

module mod_demod_step_gen #(
  parameter int ADC_BIT  = 14,
  parameter int FREQ_MIN = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [ADC_BIT-1:0] i_adc,
  input  logic [31:0]               i_freq,
  input  logic signed [31:0]        i_amp_H,
  input  logic signed [31:0]        i_amp_L,
  input  logic [31:0]               i_wait_cnt,
  input  logic signed [31:0]        i_err_offset,
  input  logic                      i_polarity,
  input  logic [31:0]               i_gain_sel,
  input  logic                      i_loop_en,
  output logic signed [31:0]        o_mod,
  output logic                      o_mod_trig,
  output logic signed [31:0]        o_err,
  output logic signed [31:0]        o_step,
  output logic                      o_step_valid
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]         state;
  logic [31:0]        cnt;
  logic [31:0]        half_q;
  logic [31:0]        wait_q;
  logic signed [31:0] amp_l_q;
  logic signed [31:0] acc_h;
  logic signed [31:0] acc_l;
  logic signed [31:0] raw_q;
  logic               raw_vld;
  logic               err_vld;

  logic [31:0]        freq_clamped;
  logic signed [31:0] adc_ext;
  logic signed [31:0] sample;
  logic               half_end;
  logic signed [31:0] acc_l_final;
  logic signed [31:0] diff;
  logic signed [31:0] raw_next;
  logic signed [31:0] err_shift;
  logic [32:0]        step_sum;
  logic signed [31:0] step_sat;
  logic               unused_gain_bits;

  assign unused_gain_bits = ^i_gain_sel[31:5];

  assign freq_clamped = (i_freq < 32'(FREQ_MIN)) ? 32'(FREQ_MIN) : i_freq;
  assign adc_ext      = {{(32-ADC_BIT){i_adc[ADC_BIT-1]}}, i_adc};
  // Samples inside the settling window contribute nothing.
  assign sample       = (cnt >= wait_q) ? adc_ext : 32'sd0;
  assign half_end     = (cnt == half_q - 32'd1);

  // The last LOW sample is added in the same edge that closes the period,
  // so the error uses the accumulator value including that sample.
  assign acc_l_final  = acc_l + sample;
  assign diff         = acc_h - acc_l_final;
  assign raw_next     = (i_polarity ? -diff : diff) - i_err_offset;

  assign err_shift    = o_err >>> i_gain_sel[4:0];
  assign step_sum     = {o_step[31], o_step} + {err_shift[31], err_shift};

  // Overflow when the two top bits of the 33-bit sum disagree.
  always_comb begin
    step_sat = step_sum[31:0];
    if (step_sum[32] != step_sum[31]) begin
      step_sat = step_sum[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_LOAD;
      cnt          <= '0;
      half_q       <= '0;
      wait_q       <= '0;
      amp_l_q      <= '0;
      acc_h        <= '0;
      acc_l        <= '0;
      raw_q        <= '0;
      raw_vld      <= 1'b0;
      err_vld      <= 1'b0;
      o_mod        <= '0;
      o_mod_trig   <= 1'b0;
      o_err        <= '0;
      o_step       <= '0;
      o_step_valid <= 1'b0;
    end else begin
      o_mod_trig   <= 1'b0;
      raw_vld      <= 1'b0;
      o_step_valid <= 1'b0;

      case (state)
        ST_LOAD: begin
          half_q  <= freq_clamped;
          wait_q  <= i_wait_cnt;
          amp_l_q <= i_amp_L;
          o_mod   <= i_amp_H;
          acc_h   <= '0;
          acc_l   <= '0;
          cnt     <= '0;
          state   <= ST_HIGH;
        end
        ST_HIGH: begin
          acc_h <= acc_h + sample;
          if (half_end) begin
            cnt   <= '0;
            acc_l <= '0;
            o_mod <= amp_l_q;
            state <= ST_LOW;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_LOW: begin
          acc_l <= acc_l_final;
          if (half_end) begin
            // Period boundary: new parameters take effect from here on.
            half_q     <= freq_clamped;
            wait_q     <= i_wait_cnt;
            amp_l_q    <= i_amp_L;
            o_mod      <= i_amp_H;
            cnt        <= '0;
            acc_h      <= '0;
            o_mod_trig <= 1'b1;
            raw_q      <= raw_next;
            raw_vld    <= 1'b1;
            state      <= ST_HIGH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_LOAD;
      endcase

      // Error pipeline: raw -> o_err -> o_step, one cycle per stage.
      err_vld <= raw_vld;
      if (raw_vld) begin
        o_err <= raw_q;
      end
      if (err_vld) begin
        o_step_valid <= 1'b1;
        o_step       <= i_loop_en ? step_sat : 32'sd0;
      end else if (!i_loop_en) begin
        o_step <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mod_demod_step_gen.sv
// tb/tb_mod_demod_step_gen.sv - self-checking scoreboard bench for mod_demod_step_gen

module tb_mod_demod_step_gen;

  localparam int ADC_BIT = 14;

  logic                      i_clk = 1'b0;
  logic                      i_rst_n = 1'b0;
  logic signed [ADC_BIT-1:0] i_adc = '0;
  logic [31:0]               i_freq = 32'd10;
  logic signed [31:0]        i_amp_H = 32'sd1000;
  logic signed [31:0]        i_amp_L = -32'sd1000;
  logic [31:0]               i_wait_cnt = 32'd2;
  logic signed [31:0]        i_err_offset = 32'sd0;
  logic                      i_polarity = 1'b0;
  logic [31:0]               i_gain_sel = 32'd0;
  logic                      i_loop_en = 1'b1;
  logic signed [31:0]        o_mod;
  logic                      o_mod_trig;
  logic signed [31:0]        o_err;
  logic signed [31:0]        o_step;
  logic                      o_step_valid;

  mod_demod_step_gen #(.ADC_BIT(ADC_BIT), .FREQ_MIN(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_adc        (i_adc),
    .i_freq       (i_freq),
    .i_amp_H      (i_amp_H),
    .i_amp_L      (i_amp_L),
    .i_wait_cnt   (i_wait_cnt),
    .i_err_offset (i_err_offset),
    .i_polarity   (i_polarity),
    .i_gain_sel   (i_gain_sel),
    .i_loop_en    (i_loop_en),
    .o_mod        (o_mod),
    .o_mod_trig   (o_mod_trig),
    .o_err        (o_err),
    .o_step       (o_step),
    .o_step_valid (o_step_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    longint err;
    longint step;
  } exp_t;

  exp_t   sb_q[$];
  bit     mon_en = 1'b0;
  int     last_edge = 0;
  int     last_trig = -100;
  int     cfg_half = 10;
  int     cfg_wait = 2;
  longint cfg_amp_h = 0;
  longint cfg_amp_l = 0;
  longint exp_step = 0;
  int     adc_hi = 100;
  int     adc_lo = -100;
  int     nvalid = 0;

  // Parameters the DUT holds for the current period.
  function automatic void latch_cfg();
    cfg_half  = (i_freq < 32'd4) ? 4 : int'(i_freq);
    cfg_wait  = int'(i_wait_cnt);
    cfg_amp_h = longint'(i_amp_H);
    cfg_amp_l = longint'(i_amp_L);
  endfunction

  function automatic longint model_err();
    int n;
    logic signed [31:0] r;
    n = (cfg_half > cfg_wait) ? cfg_half - cfg_wait : 0;
    r = 32'(n * adc_hi - n * adc_lo);
    if (i_polarity) r = -r;
    r = r - i_err_offset;
    return longint'(r);
  endfunction

  function automatic longint model_step(input longint err);
    longint s;
    if (!i_loop_en) return 0;
    s = exp_step + (err >>> i_gain_sel[4:0]);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  // Monitor: period timing, o_mod level, scoreboard push on trig and pop on valid.
  always @(negedge i_clk) begin
    int   p;
    exp_t e;
    if (mon_en) begin
      p = cyc - last_edge;
      if (o_mod_trig) begin
        check_eq("trig_period", p, 2 * cfg_half);
        e.err  = model_err();
        e.step = model_step(e.err);
        exp_step = e.step;
        sb_q.push_back(e);
        latch_cfg();
        last_edge = cyc;
        last_trig = cyc;
        p = 0;
      end
      if (p >= 0)
        check_eq("o_mod", longint'(o_mod),
                 ((p % (2 * cfg_half)) < cfg_half) ? cfg_amp_h : cfg_amp_l);
      if (o_step_valid) begin
        nvalid++;
        check_eq("valid_latency", cyc - last_trig, 2);
        if (sb_q.size() == 0) begin
          check_eq("sb_nonempty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check_eq("o_err", longint'(o_err), e.err);
          check_eq("o_step", longint'(o_step), e.step);
        end
      end
      i_adc = ADC_BIT'((p >= 0 && (p % (2 * cfg_half)) < cfg_half) ? adc_hi : adc_lo);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_mod"}, longint'(o_mod), 0);
    check_eq({tag, "_trig"}, longint'(o_mod_trig), 0);
    check_eq({tag, "_err"}, longint'(o_err), 0);
    check_eq({tag, "_step"}, longint'(o_step), 0);
    check_eq({tag, "_valid"}, longint'(o_step_valid), 0);
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    tick(2);
    check_zero_outputs("rst_held");
    sb_q.delete();
    latch_cfg();
    exp_step  = 0;
    last_trig = -100;
    last_edge = cyc + 1;
    i_rst_n   = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic run_valids(input int n);
    int tgt;
    int guard;
    tgt = nvalid + n;
    guard = 0;
    while (nvalid < tgt && guard < 2000) begin
      tick(1);
      guard++;
    end
    check_eq("valid_count", nvalid, tgt);
  endtask

  task automatic set_cfg(input int freq, input int wait_c, input int off,
                         input bit pol, input int gain, input bit loop_en);
    i_freq       = 32'(freq);
    i_wait_cnt   = 32'(wait_c);
    i_err_offset = 32'(off);
    i_polarity   = pol;
    i_gain_sel   = 32'(gain);
    i_loop_en    = loop_en;
  endtask

  initial begin
    int guard;
    tick(2);
    check_zero_outputs("power_on");

    // Basic modulation, demodulation and integration.
    set_cfg(10, 2, 0, 1'b0, 0, 1'b1);
    do_reset();
    tick(1);
    check_eq("first_high_mod", longint'(o_mod), 1000);
    run_valids(4);

    // Inverted polarity with offset.
    set_cfg(10, 2, 100, 1'b1, 0, 1'b1);
    do_reset();
    run_valids(3);

    // Clamped half-period, wait beyond the half, non-zero gain shift.
    set_cfg(2, 50, 37, 1'b0, 1, 1'b1);
    do_reset();
    run_valids(3);

    // Positive saturation of the integrator.
    set_cfg(10, 2, -1000000000, 1'b0, 0, 1'b1);
    do_reset();
    run_valids(4);
    check_eq("sat_hold", longint'(o_step), 64'sd2147483647);

    // Loop disabled: error still updates, step stays zero.
    set_cfg(10, 2, 5, 1'b0, 0, 1'b0);
    do_reset();
    run_valids(2);
    check_eq("loop_off_step", longint'(o_step), 0);

    // Mid-HIGH frequency change, then reset in the middle of a LOW half.
    set_cfg(10, 2, 0, 1'b0, 0, 1'b1);
    do_reset();
    run_valids(1);
    tick(1);
    i_freq = 32'd6;
    run_valids(2);
    guard = 0;
    while ((cyc - last_edge) != cfg_half + 2 && guard < 200) begin
      tick(1);
      guard++;
    end
    check_eq("mid_low_reached", cyc - last_edge, cfg_half + 2);
    do_reset();
    run_valids(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_demod_step_gen.md
MOD_DEMOD_STEP_GEN -- requirements
Module: mod_demod_step_gen

Interface
REQ-001 Parameter ADC_BIT, default 14, SHALL set the signed ADC sample width.
REQ-002 Parameter FREQ_MIN, default 4, SHALL set the minimum accepted half-period in clocks.
REQ-003 i_clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_adc  input  ADC_BIT signed  SHALL be the detector ADC sample, valid every clock.
REQ-006 i_freq  input  32  SHALL be the modulation half-period in clocks.
REQ-007 i_amp_H / i_amp_L  input  32 signed each  SHALL be the modulation high and low levels.
REQ-008 i_wait_cnt  input  32  SHALL be the number of settling samples skipped after each edge.
REQ-009 i_err_offset  input  32 signed  SHALL be subtracted from the raw error.
REQ-010 i_polarity  input  1  SHALL invert the error sign when 1.
REQ-011 i_gain_sel  input  32  SHALL give the integrator right-shift in bits [4:0].
REQ-012 i_loop_en  input  1  SHALL enable integration when 1.
REQ-013 o_mod  output  32 signed  SHALL be the modulation square wave (feeds phase ramp i_mod).
REQ-014 o_mod_trig  output  1  SHALL be a one-cycle pulse per completed full period (feeds ramp i_mod_trig).
REQ-015 o_err  output  32 signed  SHALL be the demodulated error of the last full period.
REQ-016 o_step  output  32 signed  SHALL be the integrated step (feeds ramp i_step).
REQ-017 o_step_valid  output  1  SHALL pulse one cycle whenever o_step is updated.

Function
REQ-018 FSM states SHALL be LOAD, HIGH and LOW; LOAD lasts exactly one cycle after reset release, then goes to HIGH with cnt=0.
REQ-019 In LOAD and on every LOW->HIGH transition, the block SHALL latch i_freq (clamped to FREQ_MIN if smaller), i_amp_H, i_amp_L and i_wait_cnt; mid-period input changes SHALL NOT take effect until then.
REQ-020 In HIGH and LOW, cnt SHALL increment each cycle; at cnt==half-1 the state SHALL toggle and cnt SHALL return to 0, so each half lasts exactly half clocks.
REQ-021 o_mod SHALL be registered: amp_H during HIGH cycles, amp_L during LOW cycles, updating in the first cycle of each half.
REQ-022 o_mod_trig SHALL assert for exactly the first cycle of each HIGH half that follows a LOW half; it SHALL NOT assert on the first HIGH after LOAD.
REQ-023 During each half, samples with cnt >= wait SHALL be sign-extended to 32 bits and summed into acc_H or acc_L; each accumulator SHALL clear at the start of its half.
REQ-024 If wait >= half, the sum for that half SHALL be 0.
REQ-025 At the LOW->HIGH transition, raw = acc_H - acc_L, negated if i_polarity, minus i_err_offset, all in 32-bit wrap arithmetic; o_err SHALL update one cycle later.
REQ-026 o_step SHALL update one cycle after o_err, together with o_step_valid.
REQ-027 The o_step update SHALL be o_step + (o_err >>> i_gain_sel[4:0]), saturated to [-2^31, 2^31-1].
REQ-028 When i_loop_en=0, o_step SHALL be forced to 0; o_err and o_step_valid SHALL still update.
REQ-029 o_step and o_err SHALL hold between updates.

Reset
REQ-030 Reset SHALL drive o_mod=0, o_mod_trig=0, o_err=0, o_step=0, o_step_valid=0, cnt=0, accumulators=0 and state=LOAD, at any point including mid-period.
REQ-031 After release, o_mod SHALL equal i_amp_H from the first HIGH cycle.

Verification
REQ-032 Scenario: freq=10, amp_H=1000, amp_L=-1000. Required: o_mod alternates every 10 clocks, and o_mod_trig pulses every 20 clocks starting with the second HIGH half.
REQ-033 Scenario: adc=+100 in HIGH and -100 in LOW, wait=2, freq=10, offset=0, gain=0, loop_en=1. Required: o_err=1600, and o_step increments by 1600 per period, 2 cycles after o_mod_trig.
REQ-034 Scenario: same as REQ-033 with polarity=1 and offset=100. Required: o_err=-1700.
REQ-035 Scenario: o_step near 2^31-1 with positive error. Required: o_step saturates at 2147483647 and does not wrap.
REQ-036 Scenario: freq=2 and wait=50. Required: half-period is 4 clocks and o_err = -offset.
REQ-037 Scenario: freq changed mid-HIGH, then reset asserted mid-LOW. Required: the new freq applies only from the next HIGH, and all outputs are 0 during reset.
